// File: rtl/control_unit_pkg.sv
// Shared types, encodings and decode helpers for the multi-cycle control unit.
package control_unit_pkg;

  typedef logic [31:0] t_data;

  typedef enum logic [2:0] {
    ALU_OP_ADD,
    ALU_OP_SUB,
    ALU_OP_XOR,
    ALU_OP_OR,
    ALU_OP_AND
  } t_alu_operation;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXECUTE,
    ST_MEMORY,
    ST_WRITEBACK,
    ST_TRAP
  } t_state;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;
  localparam logic [2:0] F3_LW      = 3'b010;
  localparam logic [2:0] F3_SW      = 3'b010;
  localparam logic [2:0] F3_BEQ     = 3'b000;
  localparam logic [2:0] F3_BNE     = 3'b001;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;

  function automatic logic is_legal(input t_data instr);
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       legal;
    opc   = instr[6:0];
    f3    = instr[14:12];
    f7    = instr[31:25];
    legal = 1'b0;
    case (opc)
      OPC_OP:     legal = ((f7 == F7_BASE) && (f3 inside {F3_ADD_SUB, F3_XOR, F3_OR, F3_AND})) ||
                          ((f7 == F7_SUB) && (f3 == F3_ADD_SUB));
      OPC_OP_IMM: legal = f3 inside {F3_ADD_SUB, F3_XOR, F3_OR, F3_AND};
      OPC_LOAD:   legal = (f3 == F3_LW);
      OPC_STORE:  legal = (f3 == F3_SW);
      OPC_BRANCH: legal = (f3 == F3_BEQ) || (f3 == F3_BNE);
      default:    legal = 1'b0;
    endcase
    return legal;
  endfunction

  // Loads, stores and anything not arithmetic fall back to ADD for address generation.
  function automatic t_alu_operation alu_op_of(input t_data instr);
    t_alu_operation op;
    op = ALU_OP_ADD;
    if (instr[6:0] == OPC_BRANCH) begin
      op = ALU_OP_SUB;
    end else if ((instr[6:0] == OPC_OP) || (instr[6:0] == OPC_OP_IMM)) begin
      case (instr[14:12])
        F3_XOR:  op = ALU_OP_XOR;
        F3_OR:   op = ALU_OP_OR;
        F3_AND:  op = ALU_OP_AND;
        default: op = ((instr[6:0] == OPC_OP) && (instr[31:25] == F7_SUB)) ? ALU_OP_SUB : ALU_OP_ADD;
      endcase
    end
    return op;
  endfunction

endpackage

// File: rtl/control_unit_imm_gen.sv
// Combinational immediate generator: sign-extended I, S or B immediate selected by opcode.
module imm_gen
  import control_unit_pkg::*;
(
  input  t_data instruction_i,
  output t_data imm_o
);

  logic unused_bits;
  assign unused_bits = ^instruction_i[19:12];

  always_comb begin
    imm_o = '0;
    case (instruction_i[6:0])
      OPC_OP_IMM, OPC_LOAD:
        imm_o = {{20{instruction_i[31]}}, instruction_i[31:20]};
      OPC_STORE:
        imm_o = {{20{instruction_i[31]}}, instruction_i[31:25], instruction_i[11:7]};
      OPC_BRANCH:
        imm_o = {{19{instruction_i[31]}}, instruction_i[31], instruction_i[7],
                 instruction_i[30:25], instruction_i[11:8], 1'b0};
      default:
        imm_o = '0;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle control FSM: fetch, decode, execute, optional memory, writeback,
// with a request timeout and a sticky trap state.
module control_unit
  import control_unit_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  output logic           o_imem_req,
  input  logic           i_imem_ack,
  input  t_data          i_instruction,
  output logic           o_dmem_req,
  output logic           o_dmem_we,
  input  logic           i_dmem_ack,
  output logic [4:0]     o_rs1,
  output logic [4:0]     o_rs2,
  output logic [4:0]     o_rd,
  output t_data          o_imm,
  output t_alu_operation o_alu_operation,
  output logic           o_alu_src_imm,
  input  logic           i_alu_zero,
  output logic           o_reg_write,
  output logic           o_wb_sel_mem,
  output logic           o_pc_write,
  output logic           o_pc_branch,
  output logic           o_trap
);

  localparam int CNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);

  t_state           state_q, state_d;
  t_data            ir_q, ir_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             taken_q, taken_d;
  logic             mem_wait;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       is_rtype, is_itype, is_load, is_store, is_branch;

  assign opcode    = ir_q[6:0];
  assign funct3    = ir_q[14:12];
  assign is_rtype  = (opcode == OPC_OP);
  assign is_itype  = (opcode == OPC_OP_IMM);
  assign is_load   = (opcode == OPC_LOAD);
  assign is_store  = (opcode == OPC_STORE);
  assign is_branch = (opcode == OPC_BRANCH);

  assign o_rs1 = ir_q[19:15];
  assign o_rs2 = ir_q[24:20];
  assign o_rd  = ir_q[11:7];

  imm_gen u_imm_gen (
    .instruction_i (ir_q),
    .imm_o         (o_imm)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_FETCH;
      ir_q    <= '0;
      cnt_q   <= '0;
      taken_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
      taken_q <= taken_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    ir_d            = ir_q;
    cnt_d           = '0;
    taken_d         = taken_q;
    mem_wait        = 1'b0;
    o_imem_req      = 1'b0;
    o_dmem_req      = 1'b0;
    o_dmem_we       = 1'b0;
    o_alu_operation = ALU_OP_ADD;
    o_alu_src_imm   = 1'b0;
    o_reg_write     = 1'b0;
    o_wb_sel_mem    = 1'b0;
    o_pc_write      = 1'b0;
    o_pc_branch     = 1'b0;
    o_trap          = 1'b0;

    case (state_q)
      // The fetch request is gated by reset so it stays low until reset is released.
      ST_FETCH: begin
        o_imem_req = i_rst_n;
        if (i_imem_ack) begin
          ir_d    = i_instruction;
          state_d = ST_DECODE;
        end else begin
          mem_wait = 1'b1;
        end
      end
      ST_DECODE: begin
        state_d = is_legal(ir_q) ? ST_EXECUTE : ST_TRAP;
      end
      ST_EXECUTE: begin
        o_alu_operation = alu_op_of(ir_q);
        o_alu_src_imm   = is_itype || is_load || is_store;
        taken_d         = is_branch && ((funct3 == F3_BNE) ? !i_alu_zero : i_alu_zero);
        state_d         = (is_load || is_store) ? ST_MEMORY : ST_WRITEBACK;
      end
      ST_MEMORY: begin
        o_dmem_req = 1'b1;
        o_dmem_we  = is_store;
        if (i_dmem_ack) begin
          state_d = ST_WRITEBACK;
        end else begin
          mem_wait = 1'b1;
        end
      end
      ST_WRITEBACK: begin
        o_pc_write   = 1'b1;
        o_reg_write  = (is_rtype || is_itype || is_load) && (o_rd != 5'd0);
        o_wb_sel_mem = is_load;
        o_pc_branch  = taken_q;
        state_d      = ST_FETCH;
      end
      ST_TRAP: begin
        o_trap = 1'b1;
      end
      default: begin
        state_d = ST_TRAP;
      end
    endcase

    // Any state change leaves cnt_d at zero; only an unanswered request keeps counting.
    if (mem_wait) begin
      if (cnt_q == CNT_W'(MEM_TIMEOUT - 1)) begin
        state_d = ST_TRAP;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

endmodule
